ps2_scancode_rx: RTL and testbench

- Receive-side PS/2 keyboard front end: oversamples the raw ps2_kbclk/ps2_kbdat pins in the clk48 domain, deglitches the clock, and deframes 11-bit PS/2 frames.
- Checks start, odd parity and stop bits, and buffers good bytes in a small FIFO.
- Presents bytes on a valid/ready symbol stream that drives the core's kb_data/kb_valid/kb_ready keyboard input directly.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/ps2_scancode_rx.sv | 157 +++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame layout, FSM states and
// default timing constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam int PS2_FRAME_BITS         = 11;
  localparam int PS2_DATA_BITS          = PS2_FRAME_BITS - 3;  // minus start, parity, stop
  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 48000;
  localparam int DEFAULT_FIFO_DEPTH     = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] head_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = head_reg;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Head is the registered read of the next head slot; a word being written
  // into that very slot bypasses the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0)
        head_reg <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin synchronisation, clock deglitching, frame
// checking and a small byte FIFO feeding a valid/ready symbol stream.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] sym_data,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       err_frame,
  output logic       err_overflow,
  input  logic       err_clr
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic           clk_meta_reg, clk_sync_reg;
  logic           dat_meta_reg, dat_sync_reg;
  logic           filt_reg;
  logic [FCW-1:0] fcnt_reg;
  logic           filt_flip;
  logic           fall_edge;

  ps2_state_e     state_reg;
  logic [2:0]     bit_cnt_reg;
  logic [7:0]     shift_reg;
  logic           parity_reg;
  logic [TW-1:0]  to_cnt_reg;
  logic           err_frame_reg;
  logic           err_ovf_reg;

  logic           timeout_hit;
  logic           good_frame;
  logic           frame_err;
  logic           pop;
  logic           fifo_push;
  logic           ovf_drop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     fifo_head;

  // Filtered clock flips on the FILTER_LEN-th consecutive disagreeing sample.
  assign filt_flip = (clk_sync_reg != filt_reg) && (fcnt_reg == FCW'(FILTER_LEN - 1));
  assign fall_edge = filt_flip && filt_reg;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_reg <= 1'b1;
      clk_sync_reg <= 1'b1;
      dat_meta_reg <= 1'b1;
      dat_sync_reg <= 1'b1;
      filt_reg     <= 1'b1;
      fcnt_reg     <= '0;
    end else begin
      clk_meta_reg <= ps2_clk;
      clk_sync_reg <= clk_meta_reg;
      dat_meta_reg <= ps2_dat;
      dat_sync_reg <= dat_meta_reg;
      if (clk_sync_reg == filt_reg) begin
        fcnt_reg <= '0;
      end else if (filt_flip) begin
        filt_reg <= clk_sync_reg;
        fcnt_reg <= '0;
      end else begin
        fcnt_reg <= fcnt_reg + FCW'(1);
      end
    end
  end

  assign timeout_hit = (state_reg != IDLE) && !fall_edge &&
                       (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign good_frame  = fall_edge && (state_reg == STOP) && dat_sync_reg &&
                       (^{shift_reg, parity_reg});
  assign frame_err   = timeout_hit ||
                       (fall_edge && (state_reg == IDLE) && dat_sync_reg) ||
                       (fall_edge && (state_reg == STOP) && !good_frame);

  assign pop       = sym_valid && sym_ready;
  assign fifo_push = good_frame && (!fifo_full || pop);
  assign ovf_drop  = good_frame && !pop && (fifo_count == CW'(FIFO_DEPTH));

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      to_cnt_reg    <= '0;
      err_frame_reg <= 1'b0;
      err_ovf_reg   <= 1'b0;
    end else begin
      // A fresh error in the same cycle as err_clr keeps the flag set.
      if (frame_err)    err_frame_reg <= 1'b1;
      else if (err_clr) err_frame_reg <= 1'b0;
      if (ovf_drop)     err_ovf_reg   <= 1'b1;
      else if (err_clr) err_ovf_reg   <= 1'b0;

      if (state_reg == IDLE || fall_edge) to_cnt_reg <= '0;
      else                                to_cnt_reg <= to_cnt_reg + TW'(1);

      if (timeout_hit) begin
        state_reg <= IDLE;
      end else if (fall_edge) begin
        case (state_reg)
          IDLE: begin
            if (!dat_sync_reg) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg   <= {dat_sync_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'(PS2_DATA_BITS - 1)) state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= dat_sync_reg;
            state_reg  <= STOP;
          end
          STOP:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk48),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (shift_reg),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign sym_data     = fifo_head;
  assign sym_valid    = !fifo_empty;
  assign err_frame    = err_frame_reg;
  assign err_overflow = err_ovf_reg;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames on the raw pins and
// checks the symbol stream and sticky flags against a frame-level model.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 3000;
  localparam int DEPTH      = 4;
  localparam int HP         = 40;   // PS/2 half period in clk48 cycles

  logic       clk48     = 1'b0;
  logic       rst_n     = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_dat   = 1'b1;
  logic       sym_ready = 1'b0;
  logic       err_clr   = 1'b0;
  logic [7:0] sym_data;
  logic       sym_valid;
  logic       err_frame;
  logic       err_overflow;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] model_q[$];
  logic [7:0] beat_log[$];
  logic       exp_frame = 1'b0;
  logic       exp_ovf   = 1'b0;

  always #10 clk48 = ~clk48;

  ps2_scancode_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .sym_data     (sym_data),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .err_frame    (err_frame),
    .err_overflow (err_overflow),
    .err_clr      (err_clr)
  );

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk48);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Frame-level rules: good frames queue up to DEPTH bytes, otherwise flags.
  task automatic model_frame(input logic [10:0] f);
    logic [7:0] b;
    b = f[8:1];
    if (f[0] == 1'b0 && f[10] == 1'b1 && ((^b) ^ f[9]) == 1'b1) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else                        exp_ovf = 1'b1;
    end else begin
      exp_frame = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      tick(HP);
      if (nbits == 11 && i == 10) model_frame(f);
      ps2_clk = 1'b0;
      tick(HP);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bits({stop, par, b, 1'b0}, 11);
    tick(100);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, " sym_valid"},    sym_valid,    model_q.size() != 0);
    check({tag, " err_frame"},    err_frame,    exp_frame);
    check({tag, " err_overflow"}, err_overflow, exp_ovf);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick(1);
    err_clr   = 1'b0;
    exp_frame = 1'b0;
    exp_ovf   = 1'b0;
    tick(2);
  endtask

  // Hand-written beat list, first byte in the most significant used byte.
  task automatic expect_log(input string tag, input int n, input logic [31:0] bytes);
    check({tag, " beat count"}, beat_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < beat_log.size())
        check({tag, " beat"}, beat_log[i], bytes[8*(n-1-i) +: 8]);
      else
        check({tag, " missing beat"}, 32'hFFFF_FFFF, bytes[8*(n-1-i) +: 8]);
    end
    beat_log.delete();
  endtask

  // Every cycle the FIFO presents a byte it must be the model's head.
  always @(negedge clk48) begin
    if (rst_n && sym_valid) begin
      vectors++;
      if (model_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat: sym_data=%02h with sym_valid=1, required no beat", sym_data);
      end else if (sym_data !== model_q[0]) begin
        miscompares++;
        $display("FAIL head: sym_data=%02h, required %02h", sym_data, model_q[0]);
      end
      if (sym_ready) begin
        beat_log.push_back(sym_data);
        if (model_q.size() != 0) void'(model_q.pop_front());
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(5);
    check("reset sym_valid", sym_valid, 1'b0);
    check("reset sym_data", sym_data, 8'h00);
    check("reset err_frame", err_frame, 1'b0);
    check("reset err_overflow", err_overflow, 1'b0);
    rst_n = 1'b1;
    tick(20);

    // Single good byte, consumer always ready.
    sym_ready = 1'b1;
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    checkpoint("t1");
    expect_log("t1", 1, 32'h1C);

    // Two bytes queued behind a stalled consumer, then drained in order.
    sym_ready = 1'b0;
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    checkpoint("t2 stalled");
    check("t2 stalled head", sym_data, 8'hF0);
    sym_ready = 1'b1;
    tick(10);
    expect_log("t2", 2, 32'hF01C);
    checkpoint("t2 drained");

    // Wrong parity bit: dropped, err_frame raised, then cleared.
    send_frame(8'h1C, 1'b1, 1'b1);
    checkpoint("t3 bad parity");
    check("t3 err_frame literal", err_frame, 1'b1);
    expect_log("t3", 0, 32'h0);
    clear_errors();
    checkpoint("t3 cleared");

    // Short clock glitch is filtered; a FILTER_LEN glitch with data high is a bad start.
    ps2_clk = 1'b0;
    tick(4);
    ps2_clk = 1'b1;
    tick(30);
    checkpoint("t4 short glitch");
    ps2_clk = 1'b0;
    tick(FILTER_LEN);
    ps2_clk = 1'b1;
    exp_frame = 1'b1;
    tick(30);
    checkpoint("t4 long glitch");
    clear_errors();

    // Partial frame then a stall: flags only once the timeout has elapsed.
    send_bits({1'b1, 1'b0, 8'hAA, 1'b0}, 4);
    tick(TIMEOUT - 200);
    checkpoint("t5 before timeout");
    tick(400);
    exp_frame = 1'b1;
    checkpoint("t5 after timeout");
    check("t5 err_frame literal", err_frame, 1'b1);
    clear_errors();
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    checkpoint("t5 recovery");
    expect_log("t5", 1, 32'h5A);

    // Five bytes into a four-entry FIFO with no consumer.
    sym_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), odd_par(8'(b)), 1'b1);
    checkpoint("t6 full");
    check("t6 err_overflow literal", err_overflow, 1'b1);
    check("t6 head literal", sym_data, 8'h01);
    sym_ready = 1'b1;
    tick(20);
    expect_log("t6", 4, 32'h01020304);
    check("t6 drained sym_valid", sym_valid, 1'b0);
    checkpoint("t6 drained");
    clear_errors();

    // Reset with a queued byte and a half-received frame discards both.
    sym_ready = 1'b0;
    send_frame(8'h33, odd_par(8'h33), 1'b1);
    send_bits({1'b1, 1'b0, 8'h77, 1'b0}, 6);
    rst_n = 1'b0;
    model_q.delete();
    exp_frame = 1'b0;
    exp_ovf   = 1'b0;
    tick(3);
    check("t7 reset sym_valid", sym_valid, 1'b0);
    check("t7 reset sym_data", sym_data, 8'h00);
    rst_n = 1'b1;
    tick(20);
    sym_ready = 1'b1;
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    checkpoint("t7 after reset");
    expect_log("t7", 1, 32'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
